sad_best_match: RTL and testbench

// - Downstream consumer of the 8-pixel SAD row stage. It accumulates ROWS row-SAD values into one block SAD per candidate.
// - It tracks the minimum block SAD across a run of candidate reference positions.
// - It reports the winning SAD and the candidate index to the motion-estimation controller.

---
 rtl/sad_pkg.sv | 16 +
 rtl/sad_row_accumulator.sv | 36 +++
 rtl/sad_best_match.sv | 143 ++++++++++++++
 tb/tb_sad_best_match.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/sad_pkg.sv
// Shared definitions for the SAD best-match block: FSM encoding and default widths.
package sad_pkg;

    localparam int DEF_ROW_W  = 11;
    localparam int DEF_ROWS   = 8;
    localparam int DEF_CAND_W = 6;
    localparam int DEF_ACC_W  = 14;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCUM   = 2'd1,
        ST_COMPARE = 2'd2,
        ST_DONE    = 2'd3
    } sad_state_t;

endpackage

// File: rtl/sad_row_accumulator.sv
// Sums ROWS row-SAD values into one block SAD; flags the final row of the block.
module sad_row_accumulator #(
    parameter int ROW_W = 11,
    parameter int ROWS  = 8,
    parameter int ACC_W = 14
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             en,
    input  logic [ROW_W-1:0] row_sad,
    output logic [ACC_W-1:0] acc,
    output logic             last_row
);

    localparam int RCW = $clog2(ROWS);

    logic [RCW-1:0] row_cnt;

    // ROWS is a power of two, so row_cnt wraps to zero on its own after the last row.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc     <= '0;
            row_cnt <= '0;
        end else if (clr) begin
            acc     <= '0;
            row_cnt <= '0;
        end else if (en) begin
            acc     <= acc + ACC_W'(row_sad);
            row_cnt <= row_cnt + 1'b1;
        end
    end

    assign last_row = (row_cnt == RCW'(ROWS - 1));

endmodule

// File: rtl/sad_best_match.sv
// Accumulates per-candidate block SADs and reports the minimum and its candidate index.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | waiting for start; best_* hold the last completed result
// ST_ACCUM   | accepting row SADs for the current candidate
// ST_COMPARE | block SAD complete; update running minimum, pick next step
// ST_DONE    | one-cycle done pulse; best_* already valid
module sad_best_match
    import sad_pkg::*;
#(
    parameter int ROW_W  = DEF_ROW_W,
    parameter int ROWS   = DEF_ROWS,
    parameter int CAND_W = DEF_CAND_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [CAND_W-1:0] last_cand,
    input  logic              abort,
    input  logic              row_valid,
    input  logic [ROW_W-1:0]  row_sad,
    output logic              row_ready,
    output logic              busy,
    output logic              done,
    output logic [ACC_W-1:0]  best_sad,
    output logic [CAND_W-1:0] best_idx
);

    sad_state_t        state_q, state_d;
    logic [CAND_W-1:0] last_cand_q;
    logic [CAND_W-1:0] cand_cnt_q;
    logic [CAND_W-1:0] run_idx_q;
    logic [ACC_W-1:0]  run_best_q;
    logic [ACC_W-1:0]  acc;
    logic              last_row;
    logic              acc_clr;
    logic              acc_en;
    logic              take_new;
    logic              final_cand;

    sad_row_accumulator #(
        .ROW_W (ROW_W),
        .ROWS  (ROWS),
        .ACC_W (ACC_W)
    ) u_acc (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr      (acc_clr),
        .en       (acc_en),
        .row_sad  (row_sad),
        .acc      (acc),
        .last_row (last_row)
    );

    // Strict compare so ties keep the earlier candidate.
    assign take_new   = (cand_cnt_q == '0) || (acc < run_best_q);
    assign final_cand = (cand_cnt_q == last_cand_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        row_ready = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        acc_clr   = 1'b0;
        acc_en    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (start && !abort) begin
                    acc_clr = 1'b1;
                    state_d = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                row_ready = 1'b1;
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (row_valid) begin
                    acc_en = 1'b1;
                    if (last_row) begin
                        state_d = ST_COMPARE;
                    end
                end
            end
            ST_COMPARE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (final_cand) begin
                    state_d = ST_DONE;
                end else begin
                    acc_clr = 1'b1;
                    state_d = ST_ACCUM;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // best_* load on the way into DONE so they are valid in the done cycle itself.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_cand_q <= '0;
            cand_cnt_q  <= '0;
            run_best_q  <= '0;
            run_idx_q   <= '0;
            best_sad    <= '0;
            best_idx    <= '0;
        end else if (!abort) begin
            if (state_q == ST_IDLE && start) begin
                last_cand_q <= last_cand;
                cand_cnt_q  <= '0;
            end else if (state_q == ST_COMPARE) begin
                if (take_new) begin
                    run_best_q <= acc;
                    run_idx_q  <= cand_cnt_q;
                end
                if (final_cand) begin
                    best_sad <= take_new ? acc : run_best_q;
                    best_idx <= take_new ? cand_cnt_q : run_idx_q;
                end else begin
                    cand_cnt_q <= cand_cnt_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sad_best_match.sv
// Randomized self-checking bench for sad_best_match against a block-sum/minimum reference model.
module tb_sad_best_match;

    localparam int ROW_W  = 11;
    localparam int ROWS   = 8;
    localparam int CAND_W = 6;
    localparam int ACC_W  = 14;
    localparam int MAXC   = 64;

    logic              clk;
    logic              reset_n;
    logic              start;
    logic [CAND_W-1:0] last_cand;
    logic              abort;
    logic              row_valid;
    logic [ROW_W-1:0]  row_sad;
    logic              row_ready;
    logic              busy;
    logic              done;
    logic [ACC_W-1:0]  best_sad;
    logic [CAND_W-1:0] best_idx;

    int n_checks;
    int n_errors;
    int rows_mem [0:MAXC*ROWS-1];

    sad_best_match #(
        .ROW_W  (ROW_W),
        .ROWS   (ROWS),
        .CAND_W (CAND_W),
        .ACC_W  (ACC_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .last_cand (last_cand),
        .abort     (abort),
        .row_valid (row_valid),
        .row_sad   (row_sad),
        .row_ready (row_ready),
        .busy      (busy),
        .done      (done),
        .best_sad  (best_sad),
        .best_idx  (best_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: sum each candidate's rows, keep the first strictly smallest sum.
    task automatic model(input int lc, output int bs, output int bi);
        int s;
        bs = 0;
        bi = 0;
        for (int c = 0; c <= lc; c++) begin
            s = 0;
            for (int r = 0; r < ROWS; r++) s += rows_mem[c*ROWS + r];
            if (c == 0 || s < bs) begin
                bs = s;
                bi = c;
            end
        end
    endtask

    task automatic fill_block(input int c, input int sum);
        for (int r = 0; r < ROWS; r++)
            rows_mem[c*ROWS + r] = sum / ROWS + ((r == 0) ? sum % ROWS : 0);
    endtask

    // mode: 0 continuous valid, 1 valid toggling, 2 random valid.
    task automatic do_search(input int lc, input int mode, input int abort_at,
                             input bit busy_start, output int done_cyc);
        int  idx;
        int  cyc;
        int  total;
        int  n_done;
        bit  hs;
        total    = (lc + 1) * ROWS;
        done_cyc = -1;
        idx      = 0;
        @(posedge clk); #1;
        start     = 1'b1;
        last_cand = CAND_W'(lc);
        @(posedge clk); #1;
        start     = 1'b0;
        last_cand = '0;
        cyc       = 1;
        while (cyc < 3000) begin
            if (done) begin
                done_cyc = cyc;
                break;
            end
            case (mode)
                0:       row_valid = (idx < total);
                1:       row_valid = (idx < total) && cyc[0];
                default: row_valid = (idx < total) && ($urandom_range(0, 1) == 1);
            endcase
            row_sad = ROW_W'(rows_mem[(idx < total) ? idx : 0]);
            if (busy_start && cyc == 3) begin
                start     = 1'b1;
                last_cand = CAND_W'(lc + 4);
            end
            if (abort_at >= 0 && idx == abort_at) begin
                abort     = 1'b1;
                row_valid = 1'b1;
            end
            hs = row_valid && row_ready && !abort;
            @(posedge clk); #1;
            cyc++;
            start     = 1'b0;
            last_cand = '0;
            if (abort) begin
                abort     = 1'b0;
                row_valid = 1'b0;
                check_val("abort_busy", busy, 0);
                check_val("abort_row_ready", row_ready, 0);
                n_done = 0;
                repeat (20) begin
                    @(posedge clk); #1;
                    if (done) n_done++;
                end
                check_val("abort_no_done", n_done, 0);
                return;
            end
            if (hs) idx++;
        end
        row_valid = 1'b0;
        check_val("done_seen", (done_cyc >= 0) ? 1 : 0, 1);
    endtask

    int dc, exp_s, exp_i, lc_r, mode_r;

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        reset_n   = 1'b0;
        start     = 1'b0;
        last_cand = '0;
        abort     = 1'b0;
        row_valid = 1'b0;
        row_sad   = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_row_ready", row_ready, 0);
        check_val("rst_best_sad", best_sad, 0);
        check_val("rst_best_idx", best_idx, 0);
        reset_n = 1'b1;

        // Single candidate, rows 1..8.
        for (int r = 0; r < ROWS; r++) rows_mem[r] = r + 1;
        do_search(0, 0, -1, 1'b0, dc);
        check_val("single_sad", best_sad, 36);
        check_val("single_idx", best_idx, 0);
        check_val("single_latency", dc, 10);

        // Asynchronous reset in the middle of a search.
        for (int c = 0; c < 4; c++) fill_block(c, 500);
        @(posedge clk); #1;
        start = 1'b1; last_cand = CAND_W'(3);
        @(posedge clk); #1;
        start = 1'b0; row_valid = 1'b1; row_sad = 11'd5;
        repeat (5) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check_val("midrst_busy", busy, 0);
        check_val("midrst_done", done, 0);
        check_val("midrst_row_ready", row_ready, 0);
        check_val("midrst_best_sad", best_sad, 0);
        check_val("midrst_best_idx", best_idx, 0);
        row_valid = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;

        // Tie keeps earliest candidate; continuous then toggling valid.
        fill_block(0, 100); fill_block(1, 40); fill_block(2, 70); fill_block(3, 40);
        do_search(3, 0, -1, 1'b0, dc);
        check_val("tie_sad", best_sad, 40);
        check_val("tie_idx", best_idx, 1);
        check_val("tie_latency", dc, 4 * (ROWS + 1) + 1);
        do_search(3, 1, -1, 1'b0, dc);
        check_val("toggle_sad", best_sad, 40);
        check_val("toggle_idx", best_idx, 1);

        // Full-scale rows across all 64 candidates.
        for (int i = 0; i < MAXC * ROWS; i++) rows_mem[i] = 2047;
        do_search(63, 0, -1, 1'b0, dc);
        check_val("max_sad", best_sad, 16376);
        check_val("max_idx", best_idx, 0);
        check_val("max_latency", dc, 64 * (ROWS + 1) + 1);

        // Restore (40,1), then abort at row 5 of candidate 2.
        fill_block(0, 100); fill_block(1, 40); fill_block(2, 70); fill_block(3, 40);
        do_search(3, 0, -1, 1'b0, dc);
        fill_block(0, 10); fill_block(1, 9); fill_block(2, 8); fill_block(3, 7);
        do_search(3, 0, 2 * ROWS + 5, 1'b0, dc);
        check_val("abort_best_sad", best_sad, 40);
        check_val("abort_best_idx", best_idx, 1);

        // Start during busy is ignored: the original last_cand governs.
        fill_block(0, 300); fill_block(1, 200);
        for (int c = 2; c < 8; c++) fill_block(c, 1);
        do_search(1, 0, -1, 1'b1, dc);
        model(1, exp_s, exp_i);
        check_val("busy_start_sad", best_sad, exp_s);
        check_val("busy_start_idx", best_idx, exp_i);
        check_val("busy_start_latency", dc, 2 * (ROWS + 1) + 1);

        // Randomized searches against the reference model.
        for (int t = 0; t < 12; t++) begin
            lc_r   = $urandom_range(0, 9);
            mode_r = $urandom_range(0, 2);
            for (int i = 0; i < (lc_r + 1) * ROWS; i++) begin
                if ($urandom_range(0, 3) == 0) rows_mem[i] = $urandom_range(0, 2047);
                else                           rows_mem[i] = $urandom_range(0, 40);
            end
            do_search(lc_r, mode_r, -1, 1'b0, dc);
            model(lc_r, exp_s, exp_i);
            check_val("rand_sad", best_sad, exp_s);
            check_val("rand_idx", best_idx, exp_i);
            if (mode_r == 0) check_val("rand_latency", dc, (lc_r + 1) * (ROWS + 1) + 1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
